// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter that shares one BRAM data port between a
//               load requester and a store-commit requester. Grants are
//               issued in the same cycle as the request. Each load tag travels
//               through a READ_LATENCY-deep pipeline so that it lines up with
//               the BRAM read data.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   READ_LATENCY  cycles from load grant to ld_resp_valid (legal 1..4)
//   TAG_W         width of the load tag
// Ports
//   clk_in, rst_in                     clock, async active-high reset
//   flush_in                           squash in-flight loads (DMEM_FLUSH_EN)
//   ld_req_valid/ready, addr, tag      load request handshake
//   st_req_valid/ready, addr,data,strb store commit handshake
//   mem_en, mem_we, mem_addr, mem_wdata  BRAM port (mem_addr = word address)
//   mem_rdata                          BRAM read data
//   ld_resp_valid, data, tag           load completion pulse, no back-pressure
// Configuration
//   DMEM_FLUSH_EN  when defined, adds flush_in and the squash behaviour
// ============================================================================
module dmem_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int TAG_W        = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
`ifdef DMEM_FLUSH_EN
    input  logic              flush_in,
`endif
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [31:0]       ld_req_addr,
    input  logic [TAG_W-1:0]  ld_req_tag,
    input  logic              st_req_valid,
    output logic              st_req_ready,
    input  logic [31:0]       st_req_addr,
    input  logic [31:0]       st_req_data,
    input  logic [3:0]        st_req_strb,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              ld_resp_valid,
    output logic [31:0]       ld_resp_data,
    output logic [TAG_W-1:0]  ld_resp_tag
);

    typedef enum logic {
        GRANT_LOAD  = 1'b0,
        GRANT_STORE = 1'b1
    } grant_e;

    grant_e                  last_grant_q;
    grant_e                  last_grant_d;
    logic [READ_LATENCY-1:0] valid_pipe_q;
    logic [READ_LATENCY-1:0] valid_pipe_d;
    logic [TAG_W-1:0]        tag_pipe_q [READ_LATENCY];
    logic [TAG_W-1:0]        tag_pipe_d [READ_LATENCY];

    logic w_flush;
    logic w_ld_elig;
    logic w_st_elig;
    logic w_grant_ld;
    logic w_grant_st;

    // Addresses are word aligned; the byte offset is intentionally dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{ld_req_addr[1:0], st_req_addr[1:0]};

`ifdef DMEM_FLUSH_EN
    assign w_flush = flush_in;
`else
    assign w_flush = 1'b0;
`endif

    // Arbitration. Reset is folded in combinationally so that the handshake
    // and BRAM port are quiet for the whole time rst_in is high, not only
    // after the first edge. A flushing cycle makes the load ineligible, which
    // lets a waiting store through.
    always_comb begin
        w_ld_elig  = ld_req_valid && !w_flush && !rst_in;
        w_st_elig  = st_req_valid && !rst_in;
        w_grant_ld = w_ld_elig && (!w_st_elig || (last_grant_q == GRANT_STORE));
        w_grant_st = w_st_elig && !w_grant_ld;
    end

    // BRAM port driven directly from the winning request.
    always_comb begin
        ld_req_ready = w_grant_ld;
        st_req_ready = w_grant_st;
        mem_en       = w_grant_ld || w_grant_st;
        mem_we       = 4'h0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        if (w_grant_ld) begin
            mem_addr = {2'b00, ld_req_addr[31:2]};
        end else if (w_grant_st) begin
            mem_we    = st_req_strb;
            mem_addr  = {2'b00, st_req_addr[31:2]};
            mem_wdata = st_req_data;
        end
    end

    // Next state: round-robin pointer and the load tag shift pipeline. The
    // pipeline shifts every cycle, granted or not, so responses come back in
    // issue order with no bubbles.
    always_comb begin
        last_grant_d = last_grant_q;
        if (w_grant_ld) begin
            last_grant_d = GRANT_LOAD;
        end else if (w_grant_st) begin
            last_grant_d = GRANT_STORE;
        end

        valid_pipe_d    = '0;
        valid_pipe_d[0] = w_grant_ld;
        tag_pipe_d[0]   = w_grant_ld ? ld_req_tag : '0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            valid_pipe_d[i] = valid_pipe_q[i-1];
            tag_pipe_d[i]   = tag_pipe_q[i-1];
        end
        // Squash: only the valid bits matter, stale tags are masked below.
        if (w_flush) begin
            valid_pipe_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_grant_q <= GRANT_STORE;
            valid_pipe_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            valid_pipe_q <= valid_pipe_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe_q[i] <= tag_pipe_d[i];
            end
        end
    end

    // Response payload is zeroed outside the valid pulse so idle outputs stay
    // quiet regardless of what the BRAM is presenting.
    always_comb begin
        ld_resp_valid = valid_pipe_q[READ_LATENCY-1];
        ld_resp_data  = ld_resp_valid ? mem_rdata : 32'h0;
        ld_resp_tag   = ld_resp_valid ? tag_pipe_q[READ_LATENCY-1] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A BRAM model answers the
//               DUT's memory port; a predictor applies the round-robin rules to
//               a reference memory and queues expected load responses, and a
//               separate monitor pops and compares them against the DUT.
//               Build with DMEM_FLUSH_EN defined to exercise the flush port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int LAT = 2;
    localparam int TW  = 4;
    localparam int W_NONE  = 0;
    localparam int W_LOAD  = 1;
    localparam int W_STORE = 2;

    logic           clk_in       = 1'b0;
    logic           rst_in       = 1'b1;
`ifdef DMEM_FLUSH_EN
    logic           flush_in     = 1'b0;
`endif
    logic           ld_req_valid = 1'b0;
    logic           ld_req_ready;
    logic [31:0]    ld_req_addr  = 32'h0;
    logic [TW-1:0]  ld_req_tag   = '0;
    logic           st_req_valid = 1'b0;
    logic           st_req_ready;
    logic [31:0]    st_req_addr  = 32'h0;
    logic [31:0]    st_req_data  = 32'h0;
    logic [3:0]     st_req_strb  = 4'h0;
    logic           mem_en;
    logic [3:0]     mem_we;
    logic [31:0]    mem_addr;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata;
    logic           ld_resp_valid;
    logic [31:0]    ld_resp_data;
    logic [TW-1:0]  ld_resp_tag;

    dmem_arbiter #(
        .READ_LATENCY (LAT),
        .TAG_W        (TW)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
`ifdef DMEM_FLUSH_EN
        .flush_in      (flush_in),
`endif
        .ld_req_valid  (ld_req_valid),
        .ld_req_ready  (ld_req_ready),
        .ld_req_addr   (ld_req_addr),
        .ld_req_tag    (ld_req_tag),
        .st_req_valid  (st_req_valid),
        .st_req_ready  (st_req_ready),
        .st_req_addr   (st_req_addr),
        .st_req_data   (st_req_data),
        .st_req_strb   (st_req_strb),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .ld_resp_valid (ld_resp_valid),
        .ld_resp_data  (ld_resp_data),
        .ld_resp_tag   (ld_resp_tag)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ---------------- BRAM model: write-first, LAT-cycle read ----------------
    logic [31:0] bram    [64];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk_in) begin
        if (mem_en && mem_we != 4'h0) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) bram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        rd_pipe[0] <= (mem_en && mem_we == 4'h0) ? bram[mem_addr[5:0]] : 32'h0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // ---------------- reference model state and scoreboard ----------------
    typedef struct {
        int            due;
        logic [31:0]   data;
        logic [TW-1:0] tag;
    } resp_t;

    logic [31:0] ref_mem [64];
    resp_t       exp_q [$];
    resp_t       keep_q [$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic logic flush_now();
`ifdef DMEM_FLUSH_EN
        return flush_in;
`else
        return 1'b0;
`endif
    endfunction

    // Predictor: decides who should win this cycle, checks the handshake and
    // BRAM port, and records the response each granted load must produce.
    int          last_win = W_STORE;
    int          win;
    logic        p_fl;
    logic [70:0] exp_v;
    logic [70:0] act_v;
    initial begin
        forever begin
            @(negedge clk_in);
            act_v = {ld_req_ready, st_req_ready, mem_en, mem_we, mem_addr, mem_wdata};
            exp_v = '0;
            if (rst_in) begin
                exp_q.delete();
                last_win = W_STORE;
            end else begin
                p_fl = flush_now();
                if ((ld_req_valid && !p_fl) && st_req_valid)
                    win = (last_win == W_STORE) ? W_LOAD : W_STORE;
                else if (ld_req_valid && !p_fl)
                    win = W_LOAD;
                else if (st_req_valid)
                    win = W_STORE;
                else
                    win = W_NONE;

                if (p_fl) begin
                    keep_q.delete();
                    foreach (exp_q[i]) if (exp_q[i].due <= cyc) keep_q.push_back(exp_q[i]);
                    exp_q = keep_q;
                end

                if (win == W_LOAD) begin
                    exp_v = {1'b1, 1'b0, 1'b1, 4'h0, {2'b00, ld_req_addr[31:2]}, 32'h0};
                    exp_q.push_back('{due: cyc + LAT, data: ref_mem[ld_req_addr[7:2]], tag: ld_req_tag});
                    last_win = W_LOAD;
                end else if (win == W_STORE) begin
                    exp_v = {1'b0, 1'b1, 1'b1, st_req_strb, {2'b00, st_req_addr[31:2]}, st_req_data};
                    for (int b = 0; b < 4; b++)
                        if (st_req_strb[b]) ref_mem[st_req_addr[7:2]][8*b +: 8] = st_req_data[8*b +: 8];
                    last_win = W_STORE;
                end
            end
            n_cmp++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL grant cyc=%0d actual{ldr,str,en,we,addr,wdata}=%h required=%h", cyc, act_v, exp_v);
            end
        end
    end

    // Monitor: checks every response pulse (and every missing one).
    resp_t e;
    initial begin
        forever begin
            @(negedge clk_in);
            #1;
            if (rst_in) begin
                n_cmp++;
                if (ld_resp_valid !== 1'b0 || ld_resp_tag !== '0) begin
                    n_fail++;
                    $display("FAIL reset_resp cyc=%0d actual valid=%b tag=%h required valid=0 tag=0", cyc, ld_resp_valid, ld_resp_tag);
                end
            end else begin
                while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++; n_fail++;
                    $display("FAIL resp_missing cyc=%0d actual none required tag=%h at cyc %0d", cyc, e.tag, e.due);
                end
                if (ld_resp_valid === 1'b1) begin
                    n_cmp++;
                    if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                        n_fail++;
                        $display("FAIL resp_unexpected cyc=%0d actual tag=%h data=%h required no response", cyc, ld_resp_tag, ld_resp_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (ld_resp_data !== e.data || ld_resp_tag !== e.tag) begin
                            n_fail++;
                            $display("FAIL resp_payload cyc=%0d actual data=%h tag=%h required data=%h tag=%h",
                                     cyc, ld_resp_data, ld_resp_tag, e.data, e.tag);
                        end
                    end
                end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++; n_fail++;
                    $display("FAIL resp_missing cyc=%0d actual valid=%b required tag=%h", cyc, ld_resp_valid, e.tag);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic ld_acc = 1'b0;
    logic st_acc = 1'b0;

    // Advance one cycle from just after a rising edge to just after the next,
    // noting which requests the DUT accepted so the driver can hold or renew.
    task automatic step();
        @(negedge clk_in);
        ld_acc = ld_req_valid && ld_req_ready;
        st_acc = st_req_valid && st_req_ready;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        ld_req_valid = 1'b0;
        st_req_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual still running required finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            bram[i]    = 32'hC0DE0000 | 32'(i);
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
        end
        bram[4]    = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        // Reset held three cycles, then idle.
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        idle(2);

        // Contended for four cycles: first winner must be the load, then alternate.
        ld_req_valid = 1'b1; ld_req_addr = 32'h40; ld_req_tag = 4'd8;
        st_req_valid = 1'b1; st_req_addr = 32'h44; st_req_data = 32'hA1B2C3D4; st_req_strb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ld_acc) begin ld_req_addr = ld_req_addr + 32'h4; ld_req_tag = ld_req_tag + 4'd1; end
            if (st_acc) begin st_req_addr = st_req_addr + 32'h8; st_req_data = ~st_req_data; st_req_strb = 4'h3; end
        end
        idle(4);

        // Single load from byte address 0x10 (word 4) with tag 5.
        ld_req_valid = 1'b1; ld_req_addr = 32'h10; ld_req_tag = 4'd5;
        step();
        idle(4);

        // Store then load to the same word on consecutive cycles.
        st_req_valid = 1'b1; st_req_addr = 32'h20; st_req_data = 32'h12345678; st_req_strb = 4'hF;
        step();
        st_req_valid = 1'b0;
        ld_req_valid = 1'b1; ld_req_addr = 32'h20; ld_req_tag = 4'd3;
        step();
        idle(4);

        // Three back-to-back loads.
        ld_req_valid = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            ld_req_addr = 32'(t) << 2;
            ld_req_tag  = TW'(t);
            step();
        end
        idle(4);

`ifdef DMEM_FLUSH_EN
        // Load tag 7 squashed by a flush on the next cycle; a later load returns.
        ld_req_valid = 1'b1; ld_req_addr = 32'h30; ld_req_tag = 4'd7;
        step();
        ld_req_valid = 1'b0;
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        ld_req_valid = 1'b1; ld_req_addr = 32'h34; ld_req_tag = 4'd9;
        step();
        idle(4);
`endif

        // Randomized traffic with a reset asserted in the middle.
        ld_acc = 1'b0;
        st_acc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                rst_in = 1'b1;
                ld_req_valid = 1'b0;
                st_req_valid = 1'b0;
                step();
                step();
                rst_in = 1'b0;
                step();
            end
            if (!ld_req_valid || ld_acc) begin
                ld_req_valid = ($urandom_range(0, 99) < 60);
                ld_req_addr  = 32'($urandom_range(0, 15)) << 2;
                ld_req_tag   = TW'($urandom);
            end
            if (!st_req_valid || st_acc) begin
                st_req_valid = ($urandom_range(0, 99) < 50);
                st_req_addr  = 32'($urandom_range(0, 15)) << 2;
                st_req_data  = $urandom;
                st_req_strb  = 4'($urandom_range(1, 15));
            end
`ifdef DMEM_FLUSH_EN
            flush_in = ($urandom_range(0, 99) < 8);
`endif
            step();
        end
`ifdef DMEM_FLUSH_EN
        flush_in = 1'b0;
`endif
        idle(LAT + 4);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual %0d responses outstanding required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
